// File: rtl/bof_range_write_arbiter.sv
// bof_range_write_arbiter: shares the overflow-range buffer's single write port
// among NUM_REQ range producers. Requests are granted round-robin, queued in a
// small FIFO and drained one write per slot, followed by a WRITE_GAP settle gap.
// A clear request sequences the buffer's user clear and flushes the queue.
// Optional build macro BOF_ARB_DEDUP_EN: a request repeating the last written
// range or the FIFO tail entry is accepted but not queued.
`timescale 1ns/1ps
module bof_range_write_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int FIFO_DEPTH   = 4,
   parameter int ADDR_W       = 32,
   parameter int WRITE_GAP    = 1,
   parameter int CLEAR_CYCLES = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ*ADDR_W-1:0] req_first_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_last_i,
   input  logic                      clear_i,
   output logic                      buf_en_write_o,
   output logic [ADDR_W-1:0]         buf_addr_first_o,
   output logic [ADDR_W-1:0]         buf_addr_last_o,
   output logic                      buf_rst_us_o,
   output logic                      busy_o,
   output logic [15:0]               drop_cnt_o
);

   typedef enum logic [1:0] {IDLE, WRITE, GAP, CLEAR} state_t;

   localparam int RR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_MAX = (CLEAR_CYCLES > WRITE_GAP) ? CLEAR_CYCLES : WRITE_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [RR_W-1:0]   rr_q, grant_idx;
   logic              grant_any, can_push, xfer, bad_range, dup_hit, push, pop;
   logic [ADDR_W-1:0] sel_first, sel_last;
   logic [ADDR_W-1:0] fifo_first [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_last  [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]    count_q;
   logic              fifo_empty, fifo_full;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));

   // Pick the first valid requester at or after the round-robin pointer.
   always_comb begin
      int idx;
      idx       = 0;
      grant_any = 1'b0;
      grant_idx = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = int'(rr_q) + off;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!grant_any && req_valid_i[RR_W'(idx)]) begin
            grant_any = 1'b1;
            grant_idx = RR_W'(idx);
         end
      end
   end

   // A clear in flight or pending blocks new pushes, as does a full queue.
   assign can_push    = rst_ni && !fifo_full && (state_q != CLEAR) && !clear_i;
   assign xfer        = grant_any && can_push;
   assign req_ready_o = xfer ? (NUM_REQ'(1) << grant_idx) : '0;
   assign sel_first   = req_first_i[grant_idx*ADDR_W +: ADDR_W];
   assign sel_last    = req_last_i[grant_idx*ADDR_W +: ADDR_W];
   assign bad_range   = (sel_first > sel_last);
   assign push        = xfer && !bad_range && !dup_hit;
   assign pop         = (state_q == IDLE) && !fifo_empty && !clear_i;

`ifdef BOF_ARB_DEDUP_EN
   logic [ADDR_W-1:0] last_wr_first_q, last_wr_last_q;
   logic [PTR_W-1:0]  tail_ptr;

   assign tail_ptr = wr_ptr_q - 1'b1;
   assign dup_hit  = ((sel_first == last_wr_first_q) && (sel_last == last_wr_last_q)) ||
                     (!fifo_empty && (sel_first == fifo_first[tail_ptr]) &&
                      (sel_last == fifo_last[tail_ptr]));

   // Remember the range most recently strobed into the buffer; a clear forgets it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_wr_first_q <= '0;
         last_wr_last_q  <= '0;
      end else if (clear_i) begin
         last_wr_first_q <= '0;
         last_wr_last_q  <= '0;
      end else if (buf_en_write_o) begin
         last_wr_first_q <= buf_addr_first_o;
         last_wr_last_q  <= buf_addr_last_o;
      end
   end
`else
   assign dup_hit = 1'b0;
`endif

   // Advance the round-robin pointer past whoever just transferred.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         rr_q <= '0;
      else if (xfer)
         rr_q <= (grant_idx == RR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
   end

   // Queue pointers and occupancy; a clear empties the queue outright.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)
            count_q <= count_q + 1'b1;
         else if (!push && pop)
            count_q <= count_q - 1'b1;
      end
   end

   // Queue storage needs no reset; occupancy alone decides what is live.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_first[wr_ptr_q] <= sel_first;
         fifo_last[wr_ptr_q]  <= sel_last;
      end
   end

   // Address outputs load on pop and hold their value otherwise.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_addr_first_o <= '0;
         buf_addr_last_o  <= '0;
      end else if (pop) begin
         buf_addr_first_o <= fifo_first[rd_ptr_q];
         buf_addr_last_o  <= fifo_last[rd_ptr_q];
      end
   end

   // Count rejected (first > last) requests, sticking at the top value.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         drop_cnt_o <= '0;
      else if (xfer && bad_range && (drop_cnt_o != 16'hFFFF))
         drop_cnt_o <= drop_cnt_o + 16'd1;
   end

   // Write-slot sequencer state and its shared gap/clear counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: pop -> write -> settle gap, with clear overriding everything.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (pop) state_d = WRITE;
         end
         WRITE: begin
            if (WRITE_GAP > 0) begin
               state_d = GAP;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         GAP: begin
            if (cnt_q == CNT_W'(WRITE_GAP - 1)) state_d = IDLE;
            else                                 cnt_d   = cnt_q + 1'b1;
         end
         CLEAR: begin
            if (cnt_q == CNT_W'(CLEAR_CYCLES - 1)) state_d = IDLE;
            else                                    cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (clear_i) begin
         state_d = CLEAR;
         cnt_d   = '0;
      end
   end

   assign buf_en_write_o = (state_q == WRITE) && !clear_i;
   assign buf_rst_us_o   = (state_q == CLEAR);
   assign busy_o         = !fifo_empty || (state_q != IDLE);

endmodule
